fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the multi-cycle cpu decode/execute sequencer.
- Drives the synchronous instruction memory, buffers fetched 8-bit instructions with their PCs in a small FIFO, and hands them downstream with a valid/ready handshake.
- Accepts PC redirects (jump/branch taken) from the downstream stage; a redirect flushes all buffered and in-flight instructions.

Parameters:
- DEPTH, 4, FIFO entries; legal 2..8.
- RESET_PC, 8'h00, fetch address after reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- fetch_en  input  1  1 = issue new reads allowed; 0 = pause issuing (in-flight read still captured)
- imem_rd_en  output  1  instruction memory read strobe (combinational)
- imem_addr  output  8  read address, = fetch_pc register
- imem_data  input  8  read data, valid the cycle after imem_rd_en was sampled
- redirect_en  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  8  new fetch address
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_instr  output  8  head instruction
- out_pc  output  8  PC of head instruction
- occupancy  output  4  current FIFO entry count

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO count, read and write pointers = 0; inflight=0.
  - out_valid=0, out_instr=0, out_pc=0, occupancy=0, imem_rd_en=0.
- Credit rule: imem_rd_en = fetch_en & ~redirect_en & (count + inflight < DEPTH). The FIFO can never overflow.
- Issue: on each edge with imem_rd_en=1:
  - fetch_pc <= fetch_pc+1, mod 256 (8'hFF wraps to 8'h00).
  - inflight <= 1; a side register captures the issued address as pc_inflight.
- Capture: on the edge after an issue, if no redirect was in the intervening cycle, imem_data and pc_inflight are written at the write pointer. inflight clears unless a new read issued the same edge.
- Latency: read issued in cycle N, out_valid=1 in cycle N+2 when the FIFO was empty. Sustained throughput is 1 instruction/cycle when out_ready=1.
- Output: show-ahead; out_instr/out_pc reflect the head entry, out_valid = (count != 0).
  - Pop on edge where out_valid & out_ready.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- Redirect (redirect_en=1 at an edge):
  - Count and both pointers cleared; any in-flight read result is discarded (kill flag set, data on the next edge ignored).
  - fetch_pc <= redirect_pc.
  - No read is issued in the redirect cycle; first read at redirect_pc is in the following cycle.
  - If out_valid & out_ready in the redirect cycle, that transfer counts as completed; the FIFO is still fully cleared.
  - Back-to-back redirects: the last one wins.
- fetch_en=0: no new issues; the FIFO keeps draining; an in-flight read still lands.
- Pointers wrap modulo DEPTH.
- occupancy = count, zero-extended.
- Reset mid-operation: everything returns to reset values immediately; any memory response after rst_n rises is ignored (inflight=0).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - perf_delivered [15:0]: increments on every out_valid & out_ready handshake.
  - perf_flushed [15:0]: adds (count + inflight, 1 if no kill pending) on each redirect.
  - Both are reset to 0 by rst_n and saturate at 16'hFFFF.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, memory returns addr^8'hA5 -> imem_addr 00,01,02… each cycle; out_valid first high 2 cycles after first rd_en; out_instr=A5,A4,A7… with out_pc=00,01,02 consecutive.
- out_ready=0, DEPTH=4 -> exactly 4 reads issued; occupancy=4; imem_rd_en stays 0; raise out_ready -> 4 entries PC 00..03 drained, then fetch resumes at 04 with no gap or duplicate.
- Redirect to 8'h40 while occupancy=3 and a read is in flight -> next cycle out_valid=0, occupancy=0; the killed read never appears; the following cycle imem_addr=40; first out_pc after the flush is 40.
- redirect_pc=8'hFE, run free -> out_pc sequence FE, FF, 00, 01 (wrap).
- fetch_en toggled 0 for 3 cycles mid-stream with an in-flight read -> in-flight instruction delivered; no addresses skipped or repeated; PCs stay contiguous.
- With FETCH_PERF_CNT_EN: 10 handshakes then a redirect with occupancy=2 and one live in-flight read -> perf_delivered=10, perf_flushed=3; assert rst_n mid-stream -> both counters 0 and out_valid=0 asynchronously.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: drives sync imem, buffers {instr,pc}, hands head downstream; perf counters under FETCH_PERF_CNT_EN.
// Latency: read issued in cycle N is visible at out_* in cycle N+2 (FIFO empty); 1 instr/cycle sustained.
// Backpressure: out_valid/out_ready; reads are only issued while a FIFO slot is guaranteed (credit on count+inflight).
module fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_en,
    output logic       imem_rd_en,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       redirect_en,
    input  logic [7:0] redirect_pc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_instr,
    output logic [7:0] out_pc,
    output logic [3:0] occupancy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_delivered,
    output logic [15:0] perf_flushed
`endif
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } entry_t;

    entry_t     fifo_q [DEPTH];
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    logic [3:0] count;
    logic       inflight;
    logic [7:0] fetch_pc;
    logic [7:0] pc_inflight;
    logic [4:0] used;
    logic       push;
    logic       pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Slots already committed: stored entries plus the read whose data is still on the bus.
    assign used       = {1'b0, count} + {4'b0, inflight};
    assign imem_rd_en = rst_n & fetch_en & ~redirect_en & (used < 5'(DEPTH));
    assign imem_addr  = fetch_pc;

    // A response arriving on the redirect edge belongs to the old stream and is dropped.
    assign push      = inflight & ~redirect_en;
    assign out_valid = (count != 4'd0);
    assign pop       = out_valid & out_ready;
    assign out_instr = fifo_q[rd_ptr].instr;
    assign out_pc    = fifo_q[rd_ptr].pc;
    assign occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            pc_inflight <= 8'h00;
            inflight    <= 1'b0;
            count       <= 4'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (redirect_en) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            count    <= 4'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                fetch_pc    <= fetch_pc + 8'd1;
                pc_inflight <= fetch_pc;
            end
            if (push) begin
                fifo_q[wr_ptr] <= '{instr: imem_data, pc: pc_inflight};
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [16:0] flush_sum;

    assign flush_sum = {1'b0, perf_flushed} + 17'(used);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_delivered <= 16'h0000;
            perf_flushed   <= 16'h0000;
        end else begin
            if (pop && perf_delivered != 16'hFFFF) begin
                perf_delivered <= perf_delivered + 16'd1;
            end
            if (redirect_en) begin
                perf_flushed <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
            end
        end
    end
`endif

endmodule
